// File: rtl/game_timer_if.sv
// game_timer_if: control/status bundle between game control and game_timer.
//   start, pause_toggle, bonus : one-cycle command pulses
//   bonus_seconds[6:0]         : seconds added on bonus
//   game_duration[6:0]         : remaining seconds, 0..MAX_SECONDS
//   running, expired           : state flags
//   expired_pulse              : one cycle on entry to expired
//   warn, blink                : low-time HUD flags
// master = game control side, slave = timer side.
interface game_timer_if;
  logic       start;
  logic       pause_toggle;
  logic       bonus;
  logic [6:0] bonus_seconds;
  logic [6:0] game_duration;
  logic       running;
  logic       expired;
  logic       expired_pulse;
  logic       warn;
  logic       blink;

  modport master (
    output start, pause_toggle, bonus, bonus_seconds,
    input  game_duration, running, expired, expired_pulse, warn, blink
  );
  modport slave (
    input  start, pause_toggle, bonus, bonus_seconds,
    output game_duration, running, expired, expired_pulse, warn, blink
  );
endinterface

// File: rtl/game_timer.sv
// game_timer: divides the clock to 1 s ticks and counts the game time down.
//   i_clk  : system clock
//   i_rst  : asynchronous active-high reset
//   bus    : game_timer_if.slave (commands in, count and flags out)
// States: IDLE -> RUNNING <-> PAUSED, RUNNING -> EXPIRED; start restarts from any.
// Optional: define GAME_TIMER_BLINK_EN to build the 1 Hz low-time blink
// phase; otherwise blink is tied low.
module game_timer #(
  parameter int CLK_HZ        = 50000000,
  parameter int START_SECONDS = 60,
  parameter int MAX_SECONDS   = 99,
  parameter int WARN_SECONDS  = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  game_timer_if.slave   bus
);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] P_HALF = PW'(CLK_HZ / 2 - 1);
  localparam logic [6:0]    D_START = 7'(START_SECONDS);
  localparam logic [7:0]    D_MAX   = 8'(MAX_SECONDS);
  localparam logic [6:0]    D_WARN  = 7'(WARN_SECONDS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXP} state_t;

  state_t        r_state;
  logic [PW-1:0] r_pre;
  logic [6:0]    r_dur;
  logic          r_pulse;
  logic          r_warn;

  logic          w_live, w_tick, w_bon, w_expire;
  logic [7:0]    w_sum;
  logic [6:0]    w_dur_live;
  state_t        w_st_nx;
  logic [6:0]    w_dur_nx;
  logic [PW-1:0] w_pre_nx;
  logic          w_warn_nx;

  assign w_live = (r_state == S_RUN) || (r_state == S_PAUSE);
  assign w_tick = (r_state == S_RUN) && (r_pre == P_LAST);
  assign w_bon  = w_live && bus.bonus && (bus.bonus_seconds != 7'd0);

  // Count is >= 1 whenever live, so the tick never underflows; the 8-bit sum
  // lets the clamp see overflow past 127.
  assign w_sum      = {1'b0, r_dur} - {7'd0, w_tick} + (w_bon ? {1'b0, bus.bonus_seconds} : 8'd0);
  assign w_dur_live = (w_sum > D_MAX) ? D_MAX[6:0] : w_sum[6:0];
  assign w_expire   = w_tick && (w_dur_live == 7'd0);

  // Start dominates; in RUN a tick lands first, then expiry beats pause.
  assign w_st_nx  = bus.start               ? S_RUN :
                    (r_state == S_RUN)      ? (w_expire ? S_EXP : (bus.pause_toggle ? S_PAUSE : S_RUN)) :
                    (r_state == S_PAUSE)    ? (bus.pause_toggle ? S_RUN : S_PAUSE) :
                    r_state;
  assign w_dur_nx = (bus.start || r_state == S_IDLE) ? D_START :
                    w_live ? w_dur_live : 7'd0;
  assign w_pre_nx = bus.start               ? '0 :
                    (r_state == S_RUN)      ? (w_tick ? '0 : r_pre + PW'(1)) :
                    (r_state == S_PAUSE)    ? r_pre : '0;
  assign w_warn_nx = ((w_st_nx == S_RUN) || (w_st_nx == S_PAUSE)) &&
                     (w_dur_nx != 7'd0) && (w_dur_nx <= D_WARN);

`ifdef GAME_TIMER_BLINK_EN
  logic r_blink;
  // Two toggles per tick period give a 1 Hz square wave aligned to the ticks.
  logic w_blink_tgl;
  assign w_blink_tgl = !bus.start && (r_state == S_RUN) && ((r_pre == P_HALF) || (r_pre == P_LAST));
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_pre   <= '0;
      r_dur   <= D_START;
      r_pulse <= 1'b0;
      r_warn  <= 1'b0;
`ifdef GAME_TIMER_BLINK_EN
      r_blink <= 1'b0;
`endif
    end else begin
      r_state <= w_st_nx;
      r_pre   <= w_pre_nx;
      r_dur   <= w_dur_nx;
      r_pulse <= !bus.start && (r_state == S_RUN) && w_expire;
      r_warn  <= w_warn_nx;
`ifdef GAME_TIMER_BLINK_EN
      r_blink <= w_warn_nx ? (r_blink ^ w_blink_tgl) : 1'b0;
`endif
    end
  end

  assign bus.game_duration = r_dur;
  assign bus.running       = (r_state == S_RUN);
  assign bus.expired       = (r_state == S_EXP);
  assign bus.expired_pulse = r_pulse;
  assign bus.warn          = r_warn;
`ifdef GAME_TIMER_BLINK_EN
  assign bus.blink         = r_blink;
`else
  assign bus.blink         = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer.sv
module tb_game_timer;
  localparam int CLK_HZ = 4, START = 12, MAXS = 99, WARN = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_timer_if ifc();
  game_timer #(.CLK_HZ(CLK_HZ), .START_SECONDS(START), .MAX_SECONDS(MAXS), .WARN_SECONDS(WARN))
    dut (.i_clk(clk), .i_rst(rst), .bus(ifc.slave));

  int n_pass = 0, n_tot = 0;

  // Reference model: mode 0=idle 1=running 2=paused 3=expired; ph = cycles into the second.
  int m_mode, m_secs, m_ph;
  bit m_pulse, m_warn, m_blink;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_all();
    chk("duration", {1'b0, ifc.game_duration}, 8'(m_secs));
    chk("running", {7'd0, ifc.running}, {7'd0, m_mode == 1});
    chk("expired", {7'd0, ifc.expired}, {7'd0, m_mode == 3});
    chk("exp_pulse", {7'd0, ifc.expired_pulse}, {7'd0, m_pulse});
    chk("warn", {7'd0, ifc.warn}, {7'd0, m_warn});
    chk("blink", {7'd0, ifc.blink}, {7'd0, m_blink});
  endtask

  task automatic model_reset();
    m_mode = 0; m_secs = START; m_ph = 0; m_pulse = 0; m_warn = 0; m_blink = 0;
  endtask

  task automatic model_edge(bit st, bit pt, bit bo, int bs);
    bit tgl, tick;
    int s;
    tgl = !st && m_mode == 1 && (m_ph == CLK_HZ/2 - 1 || m_ph == CLK_HZ - 1);
    m_pulse = 0;
    if (st) begin
      m_mode = 1; m_secs = START; m_ph = 0;
    end else if (m_mode == 1) begin
      tick = (m_ph == CLK_HZ - 1);
      m_ph = tick ? 0 : m_ph + 1;
      s = m_secs - (tick ? 1 : 0);
      if (bo && bs > 0) s = (s + bs > MAXS) ? MAXS : s + bs;
      if (s == 0) begin m_mode = 3; m_secs = 0; m_pulse = 1; end
      else begin m_secs = s; if (pt) m_mode = 2; end
    end else if (m_mode == 2) begin
      if (bo && bs > 0) m_secs = (m_secs + bs > MAXS) ? MAXS : m_secs + bs;
      if (pt) m_mode = 1;
    end
    m_warn = (m_mode == 1 || m_mode == 2) && m_secs >= 1 && m_secs <= WARN;
`ifdef GAME_TIMER_BLINK_EN
    m_blink = m_warn ? (m_blink ^ tgl) : 1'b0;
`else
    m_blink = 0;
`endif
  endtask

  task automatic step(bit st = 0, bit pt = 0, bit bo = 0, int bs = 0);
    ifc.start = st; ifc.pause_toggle = pt; ifc.bonus = bo; ifc.bonus_seconds = 7'(bs);
    @(posedge clk);
    model_edge(st, pt, bo, bs);
    #1;
    chk_all();
    ifc.start = 0; ifc.pause_toggle = 0; ifc.bonus = 0; ifc.bonus_seconds = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; #1;
    model_reset();
    chk_all();
    #1 rst = 1'b0;
  endtask

  task automatic run_until_secs(int target);
    int n = 0;
    while (m_secs != target && n < 1000) begin step(); n++; end
    if (n >= 1000) chk("timeout_secs", 8'd1, 8'd0);
  endtask

  task automatic run_until_expired();
    int n = 0;
    while (!ifc.expired && n < 1000) begin step(); n++; end
    if (n >= 1000) chk("timeout_exp", 8'd1, 8'd0);
  endtask

  initial begin
    int n;
    ifc.start = 0; ifc.pause_toggle = 0; ifc.bonus = 0; ifc.bonus_seconds = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_all();
    rst = 1'b0;

    // idle ignores pause/bonus
    step(0, 1, 1, 9);
    chk("idle_hold", {1'b0, ifc.game_duration}, 8'd12);

    // start, first two ticks
    step(1);
    chk("start_run", {7'd0, ifc.running}, 8'd1);
    repeat (4) step();
    chk("tick1", {1'b0, ifc.game_duration}, 8'd11);
    repeat (4) step();
    chk("tick2", {1'b0, ifc.game_duration}, 8'd10);
    chk("warn10", {7'd0, ifc.warn}, 8'd1);

    // expiry: one-cycle pulse, then frozen at 0
    run_until_expired();
    chk("exp_pulse_hi", {7'd0, ifc.expired_pulse}, 8'd1);
    step();
    chk("exp_pulse_lo", {7'd0, ifc.expired_pulse}, 8'd0);
    step(0, 1, 1, 5);
    chk("exp_bonus_ign", {1'b0, ifc.game_duration}, 8'd0);
    repeat (5) step();

    // pause at 7 mid-second, resume from held prescaler
    step(1);
    run_until_secs(7);
    step();
    step(0, 1);
    repeat (20) step();
    chk("paused_hold", {1'b0, ifc.game_duration}, 8'd7);
    step(0, 1);
    n = 0;
    while (ifc.game_duration == 7 && n < 10) begin step(); n++; end
    chk("resume_partial", 8'(n), 8'd2);

    // saturation via bonus while paused
    step(1);
    step(0, 1);
    step(0, 0, 1, 83);
    chk("bonus95", {1'b0, ifc.game_duration}, 8'd95);
    step(0, 0, 1, 10);
    chk("bonus_sat", {1'b0, ifc.game_duration}, 8'd99);
    step(0, 0, 1, 127);
    chk("bonus_sat127", {1'b0, ifc.game_duration}, 8'd99);
    step(0, 0, 1, 0);
    step(0, 1);

    // bonus coincident with the final tick
    step(1);
    run_until_secs(1);
    n = 0;
    while (m_ph != CLK_HZ - 1 && n < 10) begin step(); n++; end
    step(0, 0, 1, 3);
    chk("bonus_tick_dur", {1'b0, ifc.game_duration}, 8'd3);
    chk("bonus_tick_noexp", {7'd0, ifc.expired}, 8'd0);

    // pause coincident with expiring tick: expiry wins
    run_until_secs(1);
    n = 0;
    while (m_ph != CLK_HZ - 1 && n < 10) begin step(); n++; end
    step(0, 1);
    chk("pause_exp", {7'd0, ifc.expired}, 8'd1);

    // start + pause in expired -> running at START
    step(1, 1);
    chk("restart_run", {7'd0, ifc.running}, 8'd1);
    chk("restart_dur", {1'b0, ifc.game_duration}, 8'd12);

    // mid-count async reset
    repeat (9) step();
    do_reset();
    chk("rst_dur", {1'b0, ifc.game_duration}, 8'd12);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(599) == 0) do_reset();
      else step($urandom_range(79) == 0, $urandom_range(15) == 0,
                $urandom_range(9) == 0, int'($urandom_range(40)));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/game_timer.md
Name: game_timer

Overview:
- Upstream producer of the 7-bit `game_duration` value consumed by the on-screen two-digit timer renderer.
- Divides the system clock down to 1 s ticks and counts the remaining game time down from a start value.
- Runs a small state machine (idle / running / paused / expired) and supports saturating bonus-time additions.
- Drives the expiry and low-time flags used by game control and the HUD.

Parameters:
- CLK_HZ, 50000000, clock cycles per second tick (bench uses 4).
- START_SECONDS, 60, value loaded on reset and on start.
- MAX_SECONDS, 99, saturation ceiling; must be <= 99 so the two-digit renderer stays valid.
- WARN_SECONDS, 10, warn asserts when the count is >= 1 and <= this value.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse: reload START_SECONDS and run
- pause_toggle  input  1  one-cycle pulse: RUNNING<->PAUSED
- bonus  input  1  one-cycle pulse: add bonus_seconds
- bonus_seconds  input  7  amount added on bonus
- game_duration  output  7  remaining seconds, 0..MAX_SECONDS, registered
- running  output  1  high in RUNNING
- expired  output  1  high in EXPIRED
- expired_pulse  output  1  single-cycle pulse on entry to EXPIRED
- warn  output  1  low-time flag, registered
- blink  output  1  blink phase (see Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, game_duration=START_SECONDS, prescaler=0.
  - running=0, expired=0, expired_pulse=0, warn=0, blink=0.
- Prescaler:
  - 0..CLK_HZ-1 counter; increments only in RUNNING; holds in PAUSED.
  - Cleared in IDLE, in EXPIRED and on start.
  - tick = prescaler==CLK_HZ-1 while RUNNING; the prescaler wraps to 0 on the same edge.
  - Width = clog2(CLK_HZ).
- IDLE:
  - Holds START_SECONDS.
  - start -> RUNNING.
  - pause_toggle and bonus are ignored.
- RUNNING:
  - On tick: game_duration decrements by 1, visible the cycle after the tick edge.
  - pause_toggle -> PAUSED; the count and prescaler are frozen.
  - If the decrement produces 0: go to EXPIRED on the same edge; expired_pulse=1 for exactly that following cycle.
- PAUSED:
  - pause_toggle -> RUNNING; the prescaler resumes from its held value.
  - bonus is accepted.
- EXPIRED:
  - game_duration holds 0.
  - bonus and pause_toggle are ignored.
  - start -> RUNNING with START_SECONDS.
- Start:
  - Highest priority in every state.
  - Reloads START_SECONDS, clears the prescaler, enters RUNNING.
  - Overrides a same-cycle tick, bonus and pause_toggle.
- Bonus (RUNNING/PAUSED only):
  - new = min(game_duration - tick + bonus_seconds, MAX_SECONDS), computed in 8 bits before the clamp.
  - Same cycle as tick with game_duration==1 and bonus_seconds>0: the result is nonzero, so no expiry.
  - bonus_seconds=0 behaves as no bonus.
- pause_toggle and tick in the same cycle:
  - The tick is applied first, then the state changes to PAUSED.
  - If the tick expires the timer, EXPIRED wins and the pause is dropped.
- Outputs:
  - running and expired are decoded from the state register; no glitches.
  - warn is registered: 1 when 1 <= game_duration <= WARN_SECONDS and state is RUNNING or PAUSED; 0 otherwise.
- Mid-operation reset: immediate return to the reset values regardless of state.
- Invariant: game_duration never exceeds MAX_SECONDS and never goes below 0.

Optional Feature:
- Macro: GAME_TIMER_BLINK_EN.
- Defined:
  - blink toggles each time the prescaler reaches CLK_HZ/2-1 or CLK_HZ-1, i.e. a 1 Hz square wave phase-locked to the ticks.
  - This applies only while warn=1; otherwise blink=0.
  - blink holds its level in PAUSED.
  - The HUD uses it to flash the digits.
- Undefined: blink is tied to 0 and no toggle logic is built.

Test Plan (CLK_HZ=4, START_SECONDS=12, MAX_SECONDS=99, WARN_SECONDS=10):
- Reset, then start pulse → running=1; game_duration 12→11 after 4 cycles; 11→10 after 8 cycles; warn=1 once the count is 10.
- Run until 1→0 → expired=1; expired_pulse high exactly 1 cycle; game_duration=0; further cycles and a bonus(5) leave it at 0.
- Running at 7, pause_toggle → count held at 7 for 20 cycles; pause_toggle again → decrements to 6 after the remaining prescaler count, not a full 4 cycles.
- At 95, bonus_seconds=10 → 99 (saturated); bonus at 1 coincident with tick and bonus_seconds=3 → 3 and no expiry.
- In EXPIRED, start and pause_toggle in the same cycle → RUNNING at 12, not paused; assert rst mid-count → instant IDLE, game_duration=12, all flags 0.
- With GAME_TIMER_BLINK_EN and warn=1 → blink toggles every 2 cycles; without the macro → blink constant 0.
